scan_test_controller: RTL

SCAN_TEST_CONTROLLER -- requirements
Module: scan_test_controller

---
 rtl/scan_test_pkg.sv | 19 +
 rtl/sig_reg16.sv | 29 ++
 rtl/scan_test_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/scan_test_pkg.sv
// Shared types and constants for the scan test controller.
// Polynomial taps, LFSR seed and FSM state encoding.
package scan_test_pkg;

  localparam int SIG_W = 16;

  // Feedback taps r[15], r[13], r[12], r[10]
  localparam logic [SIG_W-1:0] TAP_MASK  = 16'hB400;
  localparam logic [SIG_W-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

endpackage

// File: rtl/sig_reg16.sv
// 16-bit shift register with polynomial feedback and parallel data XOR.
// Serves as the pattern LFSR (data=0) and as the response MISR.
module sig_reg16
  import scan_test_pkg::*;
#(
  parameter logic [SIG_W-1:0] SEED = '0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             clear,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] r,
  output logic [SIG_W-1:0] nxt
);

  assign nxt = {r[SIG_W-2:0], ^(r & TAP_MASK)} ^ data;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r <= SEED;
    end else if (clear) begin
      r <= '0;
    end else if (en) begin
      r <= nxt;
    end
  end

endmodule

// File: rtl/scan_test_controller.sv
// Scan BIST controller: LFSR patterns shifted into a scan chain,
// responses compacted into a MISR and compared with a golden value.
module scan_test_controller
  import scan_test_pkg::*;
#(
  parameter int               CHAIN_LEN    = 21,
  parameter int               PI_W         = 3,
  parameter int               PO_W         = 6,
  parameter int               NUM_PATTERNS = 64,
  parameter logic [SIG_W-1:0] GOLDEN       = 16'h0000
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  output logic [PI_W-1:0]  test_pi,
  output logic             scan_en,
  output logic             scan_in,
  input  logic             scan_out,
  input  logic [PO_W-1:0]  test_po,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int SW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_LAST   = PW'(NUM_PATTERNS - 1);

  state_t          state;
  logic [SW-1:0]   shift_cnt;
  logic [PW-1:0]   pat_cnt;
  logic            first_load;

  logic [SIG_W-1:0] lfsr;
  logic [SIG_W-1:0] lfsr_nxt;
  logic [SIG_W-1:0] misr_nxt;
  logic [SIG_W-1:0] misr_data;
  logic             lfsr_en;
  logic             misr_en;
  logic             misr_clr;
  logic             launch;
  logic             unused;

  assign launch   = start && (state == IDLE || state == DONE);
  assign lfsr_en  = (state == SHIFT);
  assign misr_clr = launch;
  assign misr_en  = (state == SHIFT && !first_load)
                 || state == CAPTURE
                 || state == UNLOAD;
  assign misr_data = (state == CAPTURE) ? SIG_W'(test_po)
                                        : SIG_W'(scan_out);
  assign unused = ^{lfsr[SIG_W-1:1], lfsr_nxt[SIG_W-1:PI_W]};

  sig_reg16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CK    (CK),
    .RST   (RST),
    .clear (1'b0),
    .en    (lfsr_en),
    .data  ('0),
    .r     (lfsr),
    .nxt   (lfsr_nxt)
  );

  sig_reg16 #(.SEED('0)) u_misr (
    .CK    (CK),
    .RST   (RST),
    .clear (misr_clr),
    .en    (misr_en),
    .data  (misr_data),
    .r     (signature),
    .nxt   (misr_nxt)
  );

  // Outputs are registered, so each is loaded with the value
  // it must show during the state being entered.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      shift_cnt  <= '0;
      pat_cnt    <= '0;
      first_load <= 1'b0;
      test_pi    <= '0;
      scan_en    <= 1'b0;
      scan_in    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SHIFT;
            shift_cnt  <= '0;
            pat_cnt    <= '0;
            first_load <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            scan_en    <= 1'b1;
            scan_in    <= lfsr[0];
          end
        end
        SHIFT: begin
          if (shift_cnt == SHIFT_LAST) begin
            state     <= CAPTURE;
            shift_cnt <= '0;
            scan_en   <= 1'b0;
            scan_in   <= 1'b0;
            test_pi   <= lfsr_nxt[PI_W-1:0];
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
            scan_in   <= lfsr_nxt[0];
          end
        end
        CAPTURE: begin
          pat_cnt    <= pat_cnt + 1'b1;
          first_load <= 1'b0;
          scan_en    <= 1'b1;
          if (pat_cnt == PAT_LAST) begin
            state   <= UNLOAD;
            scan_in <= 1'b0;
          end else begin
            state   <= SHIFT;
            scan_in <= lfsr[0];
          end
        end
        UNLOAD: begin
          if (shift_cnt == SHIFT_LAST) begin
            state     <= DONE;
            shift_cnt <= '0;
            scan_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (misr_nxt == GOLDEN);
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
